// File: rtl/spi_bus_arbiter_if.sv
// Requester/SPI-host side signals of spi_bus_arbiter, grouped as one bundle.
// slave: arbiter view. master: requesters plus SPI host status view.
interface spi_bus_arbiter_if #(
    parameter int NumReq = 4,
    parameter int OwnerW = $clog2(NumReq)
) ();
    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] release_i;
    logic              spi_idle_i;
    logic [NumReq-1:0] gnt_o;
    logic [OwnerW-1:0] owner_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  req_i, release_i, spi_idle_i,
        output gnt_o, owner_o, busy_o, timeout_o
    );

    modport master (
        output req_i, release_i, spi_idle_i,
        input  gnt_o, owner_o, busy_o, timeout_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbiter for a shared SPI host: grant, drain to idle, CS guard gap.
// Grant 1 cycle after request in IDLE; all outputs registered. Watchdog: SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int NumReq        = 4,
    parameter int GapCycles     = 2,
    parameter int TimeoutCycles = 1024,
    parameter int OwnerW        = $clog2(NumReq)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_GAP} state_t;

    localparam int GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    if (NumReq < 2 || NumReq > 8 || GapCycles < 0 || TimeoutCycles < 2) begin : g_param_check
        $error("spi_bus_arbiter: parameter out of range");
    end

    state_t            r_state;
    state_t            w_next;
    logic [OwnerW-1:0] r_owner;
    logic [OwnerW-1:0] r_last;
    logic [OwnerW-1:0] w_winner;
    logic              w_any_elig;
    logic [NumReq-1:0] w_elig;
    logic [NumReq-1:0] w_mask;
    logic [NumReq-1:0] r_gnt;
    logic              r_busy;
    logic              r_timeout;
    logic [GapW-1:0]   r_gap_cnt;
    logic              w_release;
    logic              w_revoke;

    assign w_elig    = bus.req_i & ~w_mask;
    // Dropping the request and pulsing release together is one release event.
    assign w_release = bus.release_i[r_owner] | ~bus.req_i[r_owner];

    always_comb begin
        int idx;
        w_winner   = r_last;
        w_any_elig = 1'b0;
        idx        = 0;
        // Walk from the farthest offset down so the nearest eligible index after last wins.
        for (int k = NumReq; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NumReq;
            if (w_elig[idx]) begin
                w_winner   = OwnerW'(idx);
                w_any_elig = 1'b1;
            end
        end
    end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    localparam int ToW = $clog2(TimeoutCycles);

    logic [ToW-1:0]    r_to_cnt;
    logic [NumReq-1:0] r_mask;

    assign w_mask   = r_mask;
    assign w_revoke = (r_state == S_GRANT) && !w_release
                      && (r_to_cnt == ToW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
            r_mask   <= '0;
        end else begin
            r_to_cnt <= (r_state == S_GRANT) ? r_to_cnt + 1'b1 : '0;
            // A revoked owner stays locked out until it lets go of its request.
            r_mask   <= (r_mask & bus.req_i)
                        | (w_revoke ? (NumReq'(1) << r_owner) : '0);
        end
    end
`else
    assign w_mask   = '0;
    assign w_revoke = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_elig) w_next = S_GRANT;
            S_GRANT: if (w_release || w_revoke) w_next = S_DRAIN;
            S_DRAIN: if (bus.spi_idle_i) w_next = (GapCycles == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (int'(r_gap_cnt) >= GapCycles - 1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_last    <= OwnerW'(NumReq - 1);
            r_owner   <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != S_IDLE);
            r_timeout <= w_revoke;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
            if (r_state == S_IDLE && w_any_elig) begin
                r_last  <= w_winner;
                r_owner <= w_winner;
                r_gnt   <= NumReq'(1) << w_winner;
            end else if (w_next != S_GRANT) begin
                r_gnt   <= '0;
            end
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.owner_o   = r_owner;
    assign bus.busy_o    = r_busy;
    assign bus.timeout_o = r_timeout;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: NumReq=4, GapCycles=2, TimeoutCycles=16.
module tb_spi_bus_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.NumReq(N)) bus ();

    spi_bus_arbiter #(
        .NumReq(N),
        .GapCycles(2),
        .TimeoutCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int max, output logic [N-1:0] g);
        int n;
        n = 0;
        g = bus.gnt_o;
        while (g == '0 && n < max) begin
            tick();
            n++;
            g = bus.gnt_o;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_o=%b required 0", name, bus.busy_o);
        end
    endtask

    task automatic test_reset;
        bus.req_i = '0; bus.release_i = '0; bus.spi_idle_i = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt_o !== 4'b0000 || bus.owner_o !== 2'd0 || bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%b owner=%0d busy=%b timeout=%b required 0/0/0/0",
                     bus.gnt_o, bus.owner_o, bus.busy_o, bus.timeout_o);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req gnt=%b busy=%b required 0000/0", bus.gnt_o, bus.busy_o);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] g;
        int order [4] = '{1, 2, 3, 0};
        int cur;
        bus.req_i = 4'b1111;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0001 || bus.owner_o !== 2'd0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rr_first gnt=%b owner=%0d busy=%b required 0001/0/1",
                     bus.gnt_o, bus.owner_o, bus.busy_o);
        end
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            bus.release_i = 4'(1 << cur);
            tick();
            bus.release_i = '0;
            wait_gnt(20, g);
            checks++;
            if (g !== 4'(1 << order[i]) || bus.owner_o !== 2'(order[i])) begin
                failures++;
                $display("FAIL rr_order%0d gnt=%b owner=%0d required %b/%0d",
                         i, g, bus.owner_o, 4'(1 << order[i]), order[i]);
            end
            cur = order[i];
        end
        bus.release_i = 4'b0001;
        bus.req_i = '0;
        tick();
        bus.release_i = '0;
        wait_idle("rr_done");
    endtask

    task automatic test_gap;
        bus.req_i = 4'b0001;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0001) begin
            failures++;
            $display("FAIL gap_setup gnt=%b required 0001", bus.gnt_o);
        end
        bus.release_i = 4'b0001;
        bus.req_i = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.release_i = '0;
            checks++;
            if (bus.gnt_o !== 4'b0000) begin
                failures++;
                $display("FAIL gap_zero%0d gnt=%b required 0000", i, bus.gnt_o);
            end
        end
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0100) begin
            failures++;
            $display("FAIL gap_next_grant gnt=%b required 0100", bus.gnt_o);
        end
    endtask

    task automatic test_idle_hold;
        bus.spi_idle_i = 1'b0;
        bus.release_i = 4'b0100;
        bus.req_i = 4'b0010;
        tick();
        bus.release_i = '0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b1) begin
                failures++;
                $display("FAIL hold_drain%0d gnt=%b busy=%b required 0000/1", i, bus.gnt_o, bus.busy_o);
            end
            tick();
        end
        bus.spi_idle_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.gnt_o !== 4'b0000) begin
                failures++;
                $display("FAIL hold_gap%0d gnt=%b required 0000", i, bus.gnt_o);
            end
        end
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0010 || bus.owner_o !== 2'd1) begin
            failures++;
            $display("FAIL hold_grant gnt=%b owner=%0d required 0010/1", bus.gnt_o, bus.owner_o);
        end
    endtask

    task automatic test_nonowner_release;
        bus.req_i = 4'b1010;
        bus.release_i = 4'b1000;
        tick();
        bus.release_i = '0;
        checks++;
        if (bus.gnt_o !== 4'b0010) begin
            failures++;
            $display("FAIL nonowner_a gnt=%b required 0010", bus.gnt_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0010 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL nonowner_b gnt=%b busy=%b required 0010/1", bus.gnt_o, bus.busy_o);
        end
        bus.release_i = 4'b0010;
        bus.req_i = '0;
        tick();
        bus.release_i = '0;
        wait_idle("nonowner_done");
    endtask

    task automatic test_watchdog;
        logic [N-1:0] g;
        int  k;
        logic bad;
        bus.req_i = 4'b0001;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0001) begin
            failures++;
            $display("FAIL wd_grant gnt=%b required 0001", bus.gnt_o);
        end
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        k = 0;
        bad = 1'b0;
        while (bus.gnt_o !== 4'b0000 && k < 40) begin
            if (bus.timeout_o !== 1'b0) bad = 1'b1;
            tick();
            k++;
        end
        checks++;
        if (k != 16 || bad) begin
            failures++;
            $display("FAIL wd_length cycles=%0d early_timeout=%b required 16/0", k, bad);
        end
        checks++;
        if (bus.timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL wd_pulse timeout=%b required 1", bus.timeout_o);
        end
        tick();
        checks++;
        if (bus.timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL wd_pulse_end timeout=%b required 0", bus.timeout_o);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt_o !== 4'b0000) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_blocked regranted=1 required 0");
        end
        bus.req_i = '0;
        tick();
        bus.req_i = 4'b0001;
        wait_gnt(20, g);
        checks++;
        if (g !== 4'b0001) begin
            failures++;
            $display("FAIL wd_regrant gnt=%b required 0001", g);
        end
`else
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.gnt_o !== 4'b0001 || bus.timeout_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_disabled grant_lost_or_timeout=1 required 0");
        end
        k = 0;
        g = '0;
`endif
        bus.release_i = 4'b0001;
        bus.req_i = '0;
        tick();
        bus.release_i = '0;
        wait_idle("wd_done");
    endtask

    task automatic test_reset_mid;
        bus.req_i = 4'b0100;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b0100 || bus.owner_o !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_setup gnt=%b owner=%0d required 0100/2", bus.gnt_o, bus.owner_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.owner_o !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_async gnt=%b busy=%b owner=%0d required 0000/0/0",
                     bus.gnt_o, bus.busy_o, bus.owner_o);
        end
        bus.req_i = '0;
        tick(); tick();
        rst = 1'b0;
        bus.req_i = 4'b1000;
        tick();
        checks++;
        if (bus.gnt_o !== 4'b1000 || bus.owner_o !== 2'd3) begin
            failures++;
            $display("FAIL rstmid_regrant gnt=%b owner=%0d required 1000/3", bus.gnt_o, bus.owner_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t required finish before 200000", $time);
        $fatal(1, "simulation time budget exhausted");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_gap();
        test_idle_hold();
        test_nonowner_release();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
